// File: rtl/snake_ram_arbiter.sv
// Round-robin arbiter sharing the single-port snake-segment RAM between the
// update sequencer (U, read/write, lockable) and the VGA renderer (R, read-only).
module snake_ram_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              u_req,
    input  logic              u_we,
    input  logic [ADDR_W-1:0] u_addr,
    input  logic [DATA_W-1:0] u_wdata,
    input  logic              u_lock,
    output logic              u_ack,
    output logic              u_rvalid,
    input  logic              r_req,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_ack,
    output logic              r_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              lock_active,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t state, state_n;
    logic   grant_u, grant_r;
    logic   last_grant_r;  // 1 = R won most recently, so U wins the next tie
    logic   cur_u;
    logic   cur_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        grant_u = 1'b0;
        grant_r = 1'b0;
        case (state)
            IDLE: begin
                if (lock_active) begin
                    grant_u = u_req;
                end else if (u_req && r_req) begin
                    grant_u = last_grant_r;
                    grant_r = !last_grant_r;
                end else begin
                    grant_u = u_req;
                    grant_r = r_req;
                end
                if (grant_u || grant_r) begin
                    state_n = ISSUE;
                end
            end
            ISSUE:   state_n = cur_we ? IDLE : RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            u_ack        <= 1'b0;
            r_ack        <= 1'b0;
            u_rvalid     <= 1'b0;
            r_rvalid     <= 1'b0;
            rdata        <= '0;
            ram_address  <= '0;
            ram_data     <= '0;
            ram_wren     <= 1'b0;
            lock_active  <= 1'b0;
            last_grant_r <= 1'b1;
            cur_u        <= 1'b0;
            cur_we       <= 1'b0;
        end else begin
            u_ack    <= grant_u;
            r_ack    <= grant_r;
            u_rvalid <= (state == RESP) && cur_u;
            r_rvalid <= (state == RESP) && !cur_u;

            if (grant_u || grant_r) begin
                ram_address  <= grant_u ? u_addr : r_addr;
                ram_data     <= grant_u ? u_wdata : '0;
                ram_wren     <= grant_u && u_we;
                cur_u        <= grant_u;
                cur_we       <= grant_u && u_we;
                last_grant_r <= grant_r;
            end else if (state == ISSUE) begin
                ram_wren <= 1'b0;
            end

            if (state == RESP) begin
                rdata <= ram_q;
            end

            // Dropping u_lock always wins over a same-edge locked grant.
            if (!u_lock) begin
                lock_active <= 1'b0;
            end else if (grant_u) begin
                lock_active <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_snake_ram_arbiter.sv
// Directed self-checking bench for snake_ram_arbiter with a 1-cycle-latency RAM model.
module tb_snake_ram_arbiter;

    logic        clk;
    logic        reset;
    logic        u_req, u_we, u_lock;
    logic [10:0] u_addr;
    logic [16:0] u_wdata;
    logic        u_ack, u_rvalid;
    logic        r_req;
    logic [10:0] r_addr;
    logic        r_ack, r_rvalid;
    logic [16:0] rdata;
    logic [10:0] ram_address;
    logic [16:0] ram_data;
    logic        ram_wren;
    logic [16:0] ram_q;
    logic        lock_active, busy;

    logic [16:0] mem [0:2047] = '{default: '0};
    logic        pl_en = 1'b0;
    logic [10:0] pl_addr = '0;
    logic [16:0] pl_data = '0;

    int checks = 0;
    int errors = 0;

    snake_ram_arbiter #(.ADDR_W(11), .DATA_W(17)) dut (
        .clk(clk), .reset(reset),
        .u_req(u_req), .u_we(u_we), .u_addr(u_addr), .u_wdata(u_wdata), .u_lock(u_lock),
        .u_ack(u_ack), .u_rvalid(u_rvalid),
        .r_req(r_req), .r_addr(r_addr), .r_ack(r_ack), .r_rvalid(r_rvalid),
        .rdata(rdata), .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_q(ram_q), .lock_active(lock_active), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM; preload port lets the bench seed contents.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [10:0] a, input logic [16:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic do_reset;
        u_req = 0; u_we = 0; u_addr = '0; u_wdata = '0; u_lock = 0;
        r_req = 0; r_addr = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        reset = 1'b1;
        tick();
        checks++;
        if ({u_ack, u_rvalid, r_ack, r_rvalid, rdata, ram_address, ram_data, ram_wren, lock_active, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got acks=%b%b rvalid=%b%b rdata=%h addr=%h data=%h wren=%b lock=%b busy=%b, want all 0",
                     u_ack, r_ack, u_rvalid, r_rvalid, rdata, ram_address, ram_data, ram_wren, lock_active, busy);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || u_ack !== 1'b0 || r_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b u_ack=%b r_ack=%b, want 0 0 0", busy, u_ack, r_ack);
        end
    endtask

    task automatic test_write_read;
        do_reset();
        u_req = 1; u_we = 1; u_addr = 11'd5; u_wdata = 17'h0A0B0;
        tick();
        checks++;
        if (u_ack !== 1'b1 || ram_wren !== 1'b1 || ram_address !== 11'd5 || ram_data !== 17'h0A0B0) begin
            errors++;
            $display("FAIL wr_accept: u_ack=%b wren=%b addr=%h data=%h, want 1 1 005 0a0b0", u_ack, ram_wren, ram_address, ram_data);
        end
        u_req = 0;
        tick();
        checks++;
        if (u_ack !== 1'b0 || ram_wren !== 1'b0 || busy !== 1'b0 || mem[5] !== 17'h0A0B0) begin
            errors++;
            $display("FAIL wr_done: u_ack=%b wren=%b busy=%b mem5=%h, want 0 0 0 0a0b0", u_ack, ram_wren, busy, mem[5]);
        end
        u_req = 1; u_we = 0; u_addr = 11'd5; u_wdata = '0;
        tick();
        checks++;
        if (u_ack !== 1'b1 || ram_wren !== 1'b0 || u_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_accept: u_ack=%b wren=%b u_rvalid=%b, want 1 0 0", u_ack, ram_wren, u_rvalid);
        end
        u_req = 0;
        tick();
        checks++;
        if (u_ack !== 1'b0 || u_rvalid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rd_wait: u_ack=%b u_rvalid=%b busy=%b, want 0 0 1", u_ack, u_rvalid, busy);
        end
        tick();
        checks++;
        if (u_rvalid !== 1'b1 || r_rvalid !== 1'b0 || rdata !== 17'h0A0B0) begin
            errors++;
            $display("FAIL rd_data: u_rvalid=%b r_rvalid=%b rdata=%h, want 1 0 0a0b0", u_rvalid, r_rvalid, rdata);
        end
        tick();
        checks++;
        if (u_rvalid !== 1'b0 || rdata !== 17'h0A0B0) begin
            errors++;
            $display("FAIL rd_hold: u_rvalid=%b rdata=%h, want 0 0a0b0", u_rvalid, rdata);
        end
    endtask

    task automatic test_round_robin;
        logic exp_u;
        logic [16:0] exp_d;
        bit got;
        do_reset();
        preload(11'd1, 17'h11111);
        preload(11'd2, 17'h02222);
        u_req = 1; u_we = 0; u_addr = 11'd1;
        r_req = 1; r_addr = 11'd2;
        for (int k = 0; k < 8; k++) begin
            exp_u = (k % 2 == 0);
            exp_d = exp_u ? 17'h11111 : 17'h02222;
            got = 0;
            for (int c = 0; c < 6 && !got; c++) begin
                tick();
                if (u_ack || r_ack) got = 1;
            end
            checks++;
            if (!got || u_ack !== exp_u || r_ack !== !exp_u) begin
                errors++;
                $display("FAIL rr_grant%0d: u_ack=%b r_ack=%b seen=%0d, want u_ack=%b r_ack=%b", k, u_ack, r_ack, got, exp_u, !exp_u);
            end
            tick();
            tick();
            checks++;
            if (u_rvalid !== exp_u || r_rvalid !== !exp_u || rdata !== exp_d) begin
                errors++;
                $display("FAIL rr_resp%0d: u_rvalid=%b r_rvalid=%b rdata=%h, want %b %b %h", k, u_rvalid, r_rvalid, rdata, exp_u, !exp_u, exp_d);
            end
        end
        u_req = 0; r_req = 0;
        tick();
    endtask

    task automatic test_lock;
        bit got;
        do_reset();
        preload(11'd3, 17'h0ABCD);
        r_req = 1; r_addr = 11'd3;
        u_req = 1; u_lock = 1; u_we = 1; u_addr = 11'd16; u_wdata = 17'h00100;
        for (int i = 0; i < 6; i++) begin
            got = 0;
            for (int c = 0; c < 6 && !got; c++) begin
                tick();
                checks++;
                if (r_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL lock_r_ack: access %0d r_ack=%b, want 0", i, r_ack);
                end
                if (u_ack) got = 1;
            end
            checks++;
            if (!got || lock_active !== 1'b1) begin
                errors++;
                $display("FAIL lock_u_ack%0d: seen=%0d lock_active=%b, want 1 1", i, got, lock_active);
            end
            u_addr = 11'd17 + 11'(i);
            u_wdata = 17'h00101 + 17'(i);
        end
        u_req = 0; u_lock = 0;
        tick();
        checks++;
        if (r_ack !== 1'b0 || lock_active !== 1'b0) begin
            errors++;
            $display("FAIL lock_release: r_ack=%b lock_active=%b, want 0 0", r_ack, lock_active);
        end
        tick();
        checks++;
        if (r_ack !== 1'b1 || u_ack !== 1'b0) begin
            errors++;
            $display("FAIL lock_r_grant: r_ack=%b u_ack=%b, want 1 0", r_ack, u_ack);
        end
        r_req = 0;
        tick();
        tick();
        checks++;
        if (r_rvalid !== 1'b1 || rdata !== 17'h0ABCD) begin
            errors++;
            $display("FAIL lock_r_data: r_rvalid=%b rdata=%h, want 1 0abcd", r_rvalid, rdata);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (mem[16 + i] !== 17'h00100 + 17'(i)) begin
                errors++;
                $display("FAIL lock_wr%0d: mem=%h, want %h", i, mem[16 + i], 17'h00100 + 17'(i));
            end
        end
    endtask

    task automatic test_lock_during_r;
        do_reset();
        preload(11'd0, 17'h12345);
        r_req = 1; r_addr = 11'd0;
        tick();
        checks++;
        if (r_ack !== 1'b1) begin
            errors++;
            $display("FAIL inflight_r_ack: r_ack=%b, want 1", r_ack);
        end
        r_req = 0;
        u_lock = 1; u_req = 1; u_we = 0; u_addr = 11'd7;
        tick();
        r_req = 1;
        tick();
        checks++;
        if (r_rvalid !== 1'b1 || rdata !== 17'h12345 || u_ack !== 1'b0) begin
            errors++;
            $display("FAIL inflight_r_data: r_rvalid=%b rdata=%h u_ack=%b, want 1 12345 0", r_rvalid, rdata, u_ack);
        end
        tick();
        checks++;
        if (u_ack !== 1'b1 || r_ack !== 1'b0 || lock_active !== 1'b1) begin
            errors++;
            $display("FAIL inflight_next_u: u_ack=%b r_ack=%b lock=%b, want 1 0 1", u_ack, r_ack, lock_active);
        end
        u_req = 0; u_lock = 0; r_req = 0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_mid_write;
        do_reset();
        preload(11'd9, 17'h00111);
        u_req = 1; u_we = 1; u_addr = 11'd9; u_wdata = 17'h1EEEE;
        tick();
        checks++;
        if (u_ack !== 1'b1 || ram_wren !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: u_ack=%b wren=%b, want 1 1", u_ack, ram_wren);
        end
        u_req = 0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (ram_wren !== 1'b0 || u_ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: wren=%b u_ack=%b busy=%b, want 0 0 0", ram_wren, u_ack, busy);
        end
        tick();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (mem[9] !== 17'h00111 || u_rvalid !== 1'b0 || u_ack !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after: mem9=%h u_rvalid=%b u_ack=%b, want 00111 0 0", mem[9], u_rvalid, u_ack);
        end
    endtask

    task automatic test_top_addr;
        int u_rv_seen;
        u_rv_seen = 0;
        do_reset();
        u_req = 1; u_we = 1; u_addr = 11'h7FF; u_wdata = 17'h1FFFF;
        tick();
        checks++;
        if (u_ack !== 1'b1 || ram_address !== 11'h7FF) begin
            errors++;
            $display("FAIL top_wr: u_ack=%b addr=%h, want 1 7ff", u_ack, ram_address);
        end
        u_req = 0;
        tick();
        r_req = 1; r_addr = 11'h7FF;
        tick();
        checks++;
        if (r_ack !== 1'b1 || ram_address !== 11'h7FF || ram_data !== 17'h0 || ram_wren !== 1'b0) begin
            errors++;
            $display("FAIL top_r_ack: r_ack=%b addr=%h data=%h wren=%b, want 1 7ff 0 0", r_ack, ram_address, ram_data, ram_wren);
        end
        r_req = 0;
        tick();
        if (u_rvalid) u_rv_seen++;
        tick();
        if (u_rvalid) u_rv_seen++;
        checks++;
        if (r_rvalid !== 1'b1 || rdata !== 17'h1FFFF || u_rv_seen != 0) begin
            errors++;
            $display("FAIL top_r_data: r_rvalid=%b rdata=%h u_rvalid_count=%0d, want 1 1ffff 0", r_rvalid, rdata, u_rv_seen);
        end
    endtask

    initial begin
        reset = 1'b1;
        u_req = 0; u_we = 0; u_addr = '0; u_wdata = '0; u_lock = 0;
        r_req = 0; r_addr = '0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_lock();
        test_lock_during_r();
        test_reset_mid_write();
        test_top_addr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
